// File: rtl/led_pattern_engine.sv
// Multi-pattern LED driver: rotate-left/right, bounce and fill-bar patterns
// stepped by a speed-selectable prescaler, with run/pause/stop control.
module led_pattern_engine #(
   parameter int N_LED       = 8,
   parameter int TICK_CYCLES = 100_000_000,
   parameter int CNT_W       = $clog2(TICK_CYCLES+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   output logic [N_LED-1:0] led,
   output logic             running,
   output logic             step
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   localparam logic [N_LED-1:0] SEED_LO = {{(N_LED-1){1'b0}}, 1'b1};
   localparam logic [N_LED-1:0] SEED_HI = {1'b1, {(N_LED-1){1'b0}}};
   localparam logic             DIR_L   = 1'b0;
   localparam logic             DIR_R   = 1'b1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pm1;
   logic [31:0]      per;
   logic             dir;
   logic [1:0]       mode_q;
   logic             pause_prev;
   logic             pause_edge;
   logic [N_LED-1:0] nxt_led;
   logic             nxt_dir;

   assign pause_edge = pause & ~pause_prev;

   // Step period tracks speed live; a shift to zero is clamped to one cycle.
   always_comb begin
      per = 32'(TICK_CYCLES) >> speed;
      pm1 = (per == 32'd0) ? '0 : CNT_W'(per - 32'd1);
   end

   always_comb begin
      nxt_led = led;
      nxt_dir = dir;
      case (mode_q)
         2'b00: nxt_led = {led[N_LED-2:0], led[N_LED-1]};
         2'b01: nxt_led = {led[0], led[N_LED-1:1]};
         2'b10: begin
            // Reverse at the ends so each end bit is lit once per sweep.
            if (dir == DIR_L) begin
               if (led[N_LED-1]) begin
                  nxt_led = led >> 1;
                  nxt_dir = DIR_R;
               end else begin
                  nxt_led = led << 1;
               end
            end else begin
               if (led[0]) begin
                  nxt_led = led << 1;
                  nxt_dir = DIR_L;
               end else begin
                  nxt_led = led >> 1;
               end
            end
         end
         default: nxt_led = (&led) ? SEED_LO : {led[N_LED-2:0], 1'b1};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         led        <= '0;
         running    <= 1'b0;
         step       <= 1'b0;
         cnt        <= '0;
         dir        <= DIR_L;
         mode_q     <= 2'b00;
         pause_prev <= 1'b0;
      end else begin
         pause_prev <= pause;
         step       <= 1'b0;
         if (stop) begin
            state   <= IDLE;
            led     <= '0;
            cnt     <= '0;
            running <= 1'b0;
         end else if (start) begin
            state   <= RUN;
            running <= 1'b1;
            mode_q  <= mode;
            cnt     <= '0;
            dir     <= DIR_L;
            led     <= (mode == 2'b01) ? SEED_HI : SEED_LO;
         end else begin
            case (state)
               RUN: begin
                  if (pause_edge) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end else if (cnt >= pm1) begin
                     cnt  <= '0;
                     led  <= nxt_led;
                     dir  <= nxt_dir;
                     step <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               PAUSE: begin
                  if (pause_edge) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with N_LED=4, TICK_CYCLES=8.
module tb_led_pattern_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [1:0] speed = 2'b00;
   logic [3:0] led;
   logic       running;
   logic       step;

   int vec = 0;
   int errs = 0;

   led_pattern_engine #(.N_LED(4), .TICK_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .mode(mode), .speed(speed), .led(led), .running(running), .step(step)
   );

   always #5 clk = ~clk;

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         vec++;
         if ({led, running, step} !== 6'b0000_0_0) begin
            errs++;
            $display("FAIL reset[%0d]: got led=%b run=%b step=%b, want 0000 0 0", i, led, running, step);
         end
      end
      start = 1'b0; rst = 1'b1;
      cyc();
   endtask

   task automatic test_rotate_left();
      logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] cur;
      mode = 2'b00; speed = 2'b00; start = 1'b1;
      cyc();
      start = 1'b0;
      vec++;
      if ({led, running, step} !== {4'b0001, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL rotl_seed: got led=%b run=%b step=%b, want 0001 1 0", led, running, step);
      end
      cur = 4'b0001;
      for (int s = 0; s < 4; s++) begin
         for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c < 8) begin
               vec++;
               if ({led, step} !== {cur, 1'b0}) begin
                  errs++;
                  $display("FAIL rotl_hold[%0d.%0d]: got led=%b step=%b, want %b 0", s, c, led, step, cur);
               end
            end else begin
               vec++;
               if ({led, running, step} !== {exp_seq[s], 1'b1, 1'b1}) begin
                  errs++;
                  $display("FAIL rotl_step[%0d]: got led=%b run=%b step=%b, want %b 1 1", s, led, running, step, exp_seq[s]);
               end
            end
         end
         cur = exp_seq[s];
      end
   endtask

   task automatic test_bounce();
      logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      mode = 2'b10; speed = 2'b11; start = 1'b1;
      cyc();
      start = 1'b0;
      vec++;
      if ({led, step} !== {4'b0001, 1'b0}) begin
         errs++;
         $display("FAIL bounce_seed: got led=%b step=%b, want 0001 0", led, step);
      end
      for (int i = 0; i < 7; i++) begin
         cyc();
         vec++;
         if ({led, step} !== {exp_seq[i], 1'b1}) begin
            errs++;
            $display("FAIL bounce[%0d]: got led=%b step=%b, want %b 1", i, led, step, exp_seq[i]);
         end
      end
   endtask

   task automatic test_fill_and_rotr();
      logic [3:0] exp_seq [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b0001};
      logic [3:0] cur;
      mode = 2'b11; speed = 2'b10; start = 1'b1;
      cyc();
      start = 1'b0;
      cur = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         cyc();
         vec++;
         if ({led, step} !== {cur, 1'b0}) begin
            errs++;
            $display("FAIL fill_hold[%0d]: got led=%b step=%b, want %b 0", i, led, step, cur);
         end
         cyc();
         vec++;
         if ({led, step} !== {exp_seq[i], 1'b1}) begin
            errs++;
            $display("FAIL fill[%0d]: got led=%b step=%b, want %b 1", i, led, step, exp_seq[i]);
         end
         cur = exp_seq[i];
      end
      mode = 2'b01; start = 1'b1;
      cyc();
      start = 1'b0;
      mode = 2'b10;   // must not affect the latched mode
      vec++;
      if ({led, running} !== {4'b1000, 1'b1}) begin
         errs++;
         $display("FAIL rotr_seed: got led=%b run=%b, want 1000 1", led, running);
      end
      cyc(); cyc();
      vec++;
      if ({led, step} !== {4'b0100, 1'b1}) begin
         errs++;
         $display("FAIL rotr_step: got led=%b step=%b, want 0100 1", led, step);
      end
      cyc(); cyc();
      vec++;
      if ({led, step} !== {4'b0010, 1'b1}) begin
         errs++;
         $display("FAIL rotr_step2: got led=%b step=%b, want 0010 1", led, step);
      end
   endtask

   task automatic test_pause();
      mode = 2'b00; speed = 2'b00; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc(); cyc();   // prescaler now at 3
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      vec++;
      if ({led, running, step} !== {4'b0001, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL pause_enter: got led=%b run=%b step=%b, want 0001 0 0", led, running, step);
      end
      for (int i = 0; i < 20; i++) begin
         cyc();
         vec++;
         if ({led, running, step} !== {4'b0001, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL pause_hold[%0d]: got led=%b run=%b step=%b, want 0001 0 0", i, led, running, step);
         end
      end
      pause = 1'b1;
      cyc();
      vec++;
      if ({running, step} !== 2'b10) begin
         errs++;
         $display("FAIL resume: got run=%b step=%b, want 1 0", running, step);
      end
      for (int c = 1; c <= 5; c++) begin
         if (c == 2) pause = 1'b0;
         cyc();
         vec++;
         if (c < 5 && {led, step} !== {4'b0001, 1'b0}) begin
            errs++;
            $display("FAIL resume_wait[%0d]: got led=%b step=%b, want 0001 0", c, led, step);
         end else if (c == 5 && {led, running, step} !== {4'b0010, 1'b1, 1'b1}) begin
            errs++;
            $display("FAIL resume_step: got led=%b run=%b step=%b, want 0010 1 1", led, running, step);
         end
      end
   endtask

   task automatic test_speed_change();
      mode = 2'b00; speed = 2'b00; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 6; i++) cyc();   // prescaler now at 6
      speed = 2'b10;
      cyc();
      vec++;
      if ({led, step} !== {4'b0010, 1'b1}) begin
         errs++;
         $display("FAIL spd_now: got led=%b step=%b, want 0010 1", led, step);
      end
      cyc();
      vec++;
      if ({led, step} !== {4'b0010, 1'b0}) begin
         errs++;
         $display("FAIL spd_gap: got led=%b step=%b, want 0010 0", led, step);
      end
      cyc();
      vec++;
      if ({led, step} !== {4'b0100, 1'b1}) begin
         errs++;
         $display("FAIL spd_next: got led=%b step=%b, want 0100 1", led, step);
      end
   endtask

   task automatic test_controls();
      stop = 1'b1; start = 1'b1;
      cyc();
      stop = 1'b0; start = 1'b0;
      vec++;
      if ({led, running, step} !== {4'b0000, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL stop_start: got led=%b run=%b step=%b, want 0000 0 0", led, running, step);
      end
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      cyc();
      vec++;
      if ({led, running} !== {4'b0000, 1'b0}) begin
         errs++;
         $display("FAIL idle_pause: got led=%b run=%b, want 0000 0", led, running);
      end
      mode = 2'b00; speed = 2'b11; start = 1'b1; pause = 1'b1;
      cyc();
      pause = 1'b0;
      vec++;
      if ({led, running, step} !== {4'b0001, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL start_pause: got led=%b run=%b step=%b, want 0001 1 0", led, running, step);
      end
      for (int i = 0; i < 3; i++) begin   // start held: continuous re-seed
         cyc();
         vec++;
         if ({led, step} !== {4'b0001, 1'b0}) begin
            errs++;
            $display("FAIL start_hold[%0d]: got led=%b step=%b, want 0001 0", i, led, step);
         end
      end
      start = 1'b0;
      cyc(); cyc();
      vec++;
      if ({led, running, step} !== {4'b0100, 1'b1, 1'b1}) begin
         errs++;
         $display("FAIL run_fast: got led=%b run=%b step=%b, want 0100 1 1", led, running, step);
      end
      rst = 1'b0; start = 1'b1;
      cyc();
      vec++;
      if ({led, running, step} !== {4'b0000, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL mid_reset: got led=%b run=%b step=%b, want 0000 0 0", led, running, step);
      end
      rst = 1'b1; start = 1'b0;
      cyc();
      vec++;
      if ({led, running} !== {4'b0000, 1'b0}) begin
         errs++;
         $display("FAIL post_reset: got led=%b run=%b, want 0000 0", led, running);
      end
   endtask

   initial begin
      test_reset();
      test_rotate_left();
      test_bounce();
      test_fill_and_rotr();
      test_pause();
      test_speed_change();
      test_controls();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor to the board's single-pattern flowing-water LED driver.
- Drives N_LED LEDs from a prescaled step tick.
- Pattern modes: rotate-left, rotate-right, bounce, fill-bar.
- Run/pause/stop control and a live speed select; sits between debounced board buttons/switches and the LED pins.

Parameters:
- N_LED, 8: number of LEDs; legal range N_LED >= 2.
- TICK_CYCLES, 100_000_000: clk cycles per step at speed 0.
- CNT_W, $clog2(TICK_CYCLES+1): prescaler counter width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-low (0 = reset, sampled on posedge clk).
- start  input  1  level; each cycle it is high (re)starts the pattern.
- stop  input  1  level; when high, returns to IDLE and blanks the LEDs.
- pause  input  1  rising edge toggles RUN<->PAUSE (edge-detected internally).
- mode  input  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 fill; latched only on start.
- speed  input  2  live; step period P = max(1, TICK_CYCLES >> speed).
- led  output  N_LED  LED drive, registered.
- running  output  1  1 only in RUN.
- step  output  1  registered one-cycle pulse, high in the cycle led shows a new step.

Behaviour:
- Reset (rst==0 at posedge), all registers cleared:
  - led=0, running=0, step=0, state=IDLE, cnt=0, dir=left, mode_q=00, pause_prev=0.
  - Reset dominates all other inputs.
- States: IDLE, RUN, PAUSE.
- Input priority each cycle: stop > start > pause edge.
- stop (any state): state=IDLE, led=0, cnt=0, step=0.
- start (any state, stop low):
  - mode_q<=mode, cnt<=0, dir<=left, state=RUN.
  - Seed led: mode 01 -> 1 in bit N_LED-1 only; modes 00, 10 and 11 -> 1 in bit 0 only (i.e. led=1).
  - Holding start high keeps re-seeding, so no steps occur while it is held.
- pause: pause_edge = pause & ~pause_prev; pause_prev registered every cycle including in IDLE.
  - RUN + edge -> PAUSE. PAUSE + edge -> RUN. Edge in IDLE is ignored.
  - PAUSE freezes both cnt and led; on resume, counting continues from the held cnt.
- Prescaler (RUN only):
  - If cnt >= P-1: cnt<=0, advance led one step, step<=1.
  - Otherwise cnt<=cnt+1, step<=0.
  - The >= compare covers a speed change that leaves cnt above the new P-1: the step fires on the next cycle.
  - P=1 steps every cycle.
- Latency: start sampled at edge k -> seed visible after edge k; first step at edge k+P, then every P edges.
- Step rules:
  - rotate-left: led <= {led[N-2:0], led[N-1]}.
  - rotate-right: led <= {led[0], led[N-1:1]}.
  - bounce: shift toward dir.
    - At bit N_LED-1 with dir=left: move to bit N_LED-2, dir<=right.
    - At bit 0 with dir=right: move to bit 1, dir<=left.
    - End bits are shown once per sweep; period 2*N_LED-2 steps.
  - fill: if led all ones -> led<=1; else led <= {led[N-2:0], 1'b1}. Period N_LED steps.
- Mode-input changes while running have no effect until the next start.
- step=0 in IDLE and PAUSE; running=0 in IDLE and PAUSE.

Test Plan:
(All with N_LED=4, TICK_CYCLES=8.)
1. Hold rst=0 3 cycles with start=1 -> led=0000, running=0, step=0. Release, pulse start 1 cycle with mode=00, speed=0 -> led 0001 / 0010 / 0100 / 1000 / 0001, one step every 8 clks. step high exactly on each change.
2. mode=10, speed=3 (P=1) -> led 0001,0010,0100,1000,0100,0010,0001,0010 on successive cycles.
3. mode=11, speed=2 (P=2) -> 0001,0011,0111,1111,0001 every 2 clks. mode=01 start -> seed 1000, then 0100.
4. Mode 00, speed=0 with cnt=3. Pause edge -> led and cnt frozen for 20 clks, running=0. Second pause edge -> next step exactly 5 clks after resume.
5. Speed 0 with cnt=6, switch to speed=2 -> step on the next cycle, then every 2 clks.
6. Simultaneous stop+start -> IDLE, led=0000. start+pause edge -> RUN with seed, not PAUSE. rst=0 mid-RUN -> all outputs 0 next cycle.
